interboard_tx_scheduler: RTL and testbench
==========================================

Name: interboard_tx_scheduler

Overview:
- Shares the single interboard transmit channel among N_REQ local message producers, e.g. game master and keyboard/status logic.
- Arbitrates round-robin and launches one message at a time into the interboard communication block.
- Tracks link busy/idle via inter_ready, retries launches the link does not pick up, and reports done/error per message.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- ACK_TIMEOUT, 1024, cycles to wait for inter_ready to fall after a launch.
- DONE_TIMEOUT, 65536, cycles to wait for inter_ready to return high once busy.
- MAX_RETRY, 3, relaunches allowed after an ACK_TIMEOUT before the message is dropped.

Ports:
- clk  in  1  system clock (50 MHz domain)
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  N_REQ  per-requester message pending
- req_msg_type  in  3*N_REQ  per-requester message type; requester i uses bits [3i+2:3i]
- req_number  in  5*N_REQ  per-requester number payload; requester i uses bits [5i+4:5i]
- req_ready  out  N_REQ  one-hot accept strobe
- inter_ready  in  1  link idle/ready from the interboard communication block
- transmit  out  1  one-cycle launch strobe
- ctrl_en  out  1  equal to transmit
- ctrl_msg_type  out  3  launched message type, held
- ctrl_number  out  5  launched number, held
- busy  out  1  high in any state other than IDLE
- grant_id  out  3  index of the requester currently being served
- tx_done  out  1  one-cycle pulse when a message completes
- tx_error  out  1  one-cycle pulse when a message is dropped

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0; ctrl_msg_type=0, ctrl_number=0, grant_id=0.
  - RR pointer=0, timer=0, retry count=0.
  - Reset mid-transfer abandons the message silently, with no tx_done or tx_error.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If inter_ready=1 and any req_valid=1, req_ready[g]=1 combinationally, where g is the first valid index searching from ptr upward with wrap.
  - On that cycle: capture the msg_type/number slice of g into ctrl_msg_type/ctrl_number; grant_id<=g; ptr<=(g+1) mod N_REQ; retry<=0; go to LAUNCH.
  - If inter_ready=0, req_ready stays all 0 and no grant is made.
  - A requester holds valid and payload until it sees ready. Dropping valid before ready is legal and nothing is captured.
- LAUNCH:
  - transmit=ctrl_en=1 for exactly this one cycle.
  - timer<=0; go to WAIT_BUSY.
  - Latency: message launched 1 cycle after its accept.
- WAIT_BUSY:
  - If inter_ready=0: go to WAIT_DONE, timer<=0.
  - Else timer++. When timer reaches ACK_TIMEOUT-1:
    - If retry<MAX_RETRY: retry++, go to LAUNCH with the same payload.
    - Else: tx_error pulse, go to IDLE.
- WAIT_DONE:
  - If inter_ready=1: tx_done pulse, go to IDLE.
  - Else timer++. At DONE_TIMEOUT-1: tx_error pulse, go to IDLE.
  - No retry here, because the link already accepted the message.
- ctrl_msg_type, ctrl_number and grant_id hold their values from capture until the next capture.
- Back-to-back: after tx_done, the next grant may be made in the cycle after the return to IDLE, so there is at least 1 idle cycle between messages.
- Fairness: a requester holding valid continuously is served within N_REQ grants.
- Timer width: clog2(DONE_TIMEOUT). Retry counter width: clog2(MAX_RETRY+1).
- N_REQ=1: the arbiter degenerates to a pass-through and ptr stays 0.

Decomposition:
- Shared package interboard_pkg:
  - MSG_TYPE_W=3, NUM_W=5.
  - Message-type constants shared with the game master.
  - State encoding for this block.
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register stays in the scheduler.

Test Plan:
- Single request: req_valid[0]=1, type=3'd2, number=5'd17, inter_ready=1; link model drops inter_ready 2 cycles after transmit and raises it 10 cycles later.
  - Required: req_ready[0] pulses once; transmit 1 cycle later with ctrl_msg_type=2 and ctrl_number=17; tx_done exactly once when inter_ready rises.
- Contention: req_valid=2'b11 held for 4 messages.
  - Required: grant_id sequence 0,1,0,1, and each req_ready coincides with its capture.
- Link busy: inter_ready=0 while req_valid[1]=1.
  - Required: no req_ready and no transmit until inter_ready=1; grant follows in that same cycle.
- No pickup: inter_ready stuck at 1 after launch, ACK_TIMEOUT=8, MAX_RETRY=3.
  - Required: 4 transmit pulses spaced 9 cycles apart, then one tx_error pulse, then IDLE with busy=0.
- Hang: inter_ready falls, then never returns, DONE_TIMEOUT=16.
  - Required: tx_error pulse 16 cycles after entering WAIT_DONE; no relaunch.
- Reset mid-transfer: rst=0 during WAIT_DONE.
  - Required: all outputs 0 immediately (asynchronous) and no pulse. After release, ptr=0, so requester 0 wins the next contention.

Source files
------------

// File: rtl/interboard_tx_scheduler_pkg.sv
// Purpose: shared widths, message-type codes and scheduler state encoding for the interboard link.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package interboard_pkg;

  localparam int MSG_TYPE_W = 3;
  localparam int NUM_W      = 5;
  localparam int GRANT_W    = 3;

  // Message-type codes understood by the peer board; the game master uses the same table.
  typedef enum logic [MSG_TYPE_W-1:0] {
    MSG_NOP    = 3'd0,
    MSG_SCORE  = 3'd1,
    MSG_LIVES  = 3'd2,
    MSG_KEY    = 3'd3,
    MSG_START  = 3'd4,
    MSG_OVER   = 3'd5,
    MSG_STATUS = 3'd6,
    MSG_SYNC   = 3'd7
  } msg_type_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/interboard_tx_scheduler_if.sv
// Purpose: requester + link + status bundle of the interboard transmit scheduler.
// Latency: n/a. Backpressure: req_valid/req_ready per requester; inter_ready gates new launches.
// Ports: master = producers and link model side, slave = scheduler side.
interface interboard_tx_scheduler_if #(
  parameter int N_REQ = 2
);
  import interboard_pkg::*;

  logic [N_REQ-1:0]            req_valid;
  logic [MSG_TYPE_W*N_REQ-1:0] req_msg_type;
  logic [NUM_W*N_REQ-1:0]      req_number;
  logic [N_REQ-1:0]            req_ready;
  logic                        inter_ready;
  logic                        transmit;
  logic                        ctrl_en;
  logic [MSG_TYPE_W-1:0]       ctrl_msg_type;
  logic [NUM_W-1:0]            ctrl_number;
  logic                        busy;
  logic [GRANT_W-1:0]          grant_id;
  logic                        tx_done;
  logic                        tx_error;

  modport master (
    output req_valid, req_msg_type, req_number, inter_ready,
    input  req_ready, transmit, ctrl_en, ctrl_msg_type, ctrl_number,
           busy, grant_id, tx_done, tx_error
  );

  modport slave (
    input  req_valid, req_msg_type, req_number, inter_ready,
    output req_ready, transmit, ctrl_en, ctrl_msg_type, ctrl_number,
           busy, grant_id, tx_done, tx_error
  );

endinterface

// File: rtl/interboard_tx_scheduler_rr_arbiter.sv
// Purpose: round-robin pick of the first requesting index at or after i_ptr, with wrap.
// Latency: purely combinational. Backpressure: i_en=0 forces no grant.
// Ports: i_req/i_ptr/i_en in; o_grant (one-hot), o_grant_idx, o_grant_vld out.
module rr_arbiter
  import interboard_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]       i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [N-1:0]       o_grant,
  output logic [GRANT_W-1:0] o_grant_idx,
  output logic               o_grant_vld
);

  int w_dist;
  int w_best_dist;
  int w_best;

  // Priority is the distance from the pointer going upward; the smallest
  // distance among active requesters wins, which gives the wrap for free.
  always_comb begin
    w_dist      = 0;
    w_best_dist = N;
    w_best      = 0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - int'(i_ptr)) % N;
      if (i_en && i_req[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best      = j;
      end
    end
    o_grant_vld = (w_best_dist < N);
    o_grant     = '0;
    for (int j = 0; j < N; j++) begin
      o_grant[j] = o_grant_vld && (j == w_best);
    end
    o_grant_idx = GRANT_W'(w_best);
  end

endmodule

// File: rtl/interboard_tx_scheduler.sv
// Purpose: shares the interboard transmit channel among N_REQ producers, one message at a time.
// Latency: accept -> transmit 1 cycle; tx_done/tx_error registered, 1 cycle after the deciding cycle.
// Backpressure: req_ready only while idle and inter_ready=1; unanswered launches retried up to MAX_RETRY.
// Ports: i_clk, i_rst_n (async, active-low), bus (slave modport of interboard_tx_scheduler_if).
module interboard_tx_scheduler
  import interboard_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int ACK_TIMEOUT  = 1024,
  parameter int DONE_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  interboard_tx_scheduler_if.slave bus
);

  localparam int PTR_W = clog2_min1(N_REQ);
  localparam int TMR_W = clog2_min1(DONE_TIMEOUT);
  localparam int RTY_W = clog2_min1(MAX_RETRY + 1);
  // ACK_TIMEOUT is expected not to exceed DONE_TIMEOUT so both limits fit the shared timer.
  localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DONE_LAST = TMR_W'(DONE_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  tx_state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]      r_ptr;
  logic [TMR_W-1:0]      r_timer;
  logic [RTY_W-1:0]      r_retry;
  logic [MSG_TYPE_W-1:0] r_ctrl_msg_type;
  logic [NUM_W-1:0]      r_ctrl_number;
  logic [GRANT_W-1:0]    r_grant_id;
  logic                  r_tx_done;
  logic                  r_tx_error;

  logic [N_REQ-1:0]      w_grant;
  logic [GRANT_W-1:0]    w_grant_idx;
  logic                  w_grant_vld;
  logic                  w_arb_en;
  logic [MSG_TYPE_W-1:0] w_sel_type;
  logic [NUM_W-1:0]      w_sel_num;
  logic                  w_capture, w_timer_clr, w_timer_inc, w_retry_inc, w_done, w_error;

  // Reset is folded in so req_ready is low while reset is held.
  assign w_arb_en = i_rst_n && (r_state == ST_IDLE) && bus.inter_ready;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
    .i_req       (bus.req_valid),
    .i_ptr       (r_ptr),
    .i_en        (w_arb_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  always_comb begin
    w_sel_type = '0;
    w_sel_num  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_grant[j]) begin
        w_sel_type = bus.req_msg_type[MSG_TYPE_W*j +: MSG_TYPE_W];
        w_sel_num  = bus.req_number[NUM_W*j +: NUM_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timer_clr = 1'b0;
    w_timer_inc = 1'b0;
    w_retry_inc = 1'b0;
    w_done      = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_timer_clr = 1'b1;
        w_state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!bus.inter_ready) begin
          w_timer_clr = 1'b1;
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_timer == ACK_LAST) begin
          // Link never went busy: relaunch the held payload or give up.
          if (r_retry < RTY_MAX) begin
            w_retry_inc = 1'b1;
            w_state_nxt = ST_LAUNCH;
          end else begin
            w_error     = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        // The link owns the message now, so a hang is reported, never relaunched.
        if (bus.inter_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_timer == DONE_LAST) begin
          w_error     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr           <= '0;
      r_timer         <= '0;
      r_retry         <= '0;
      r_ctrl_msg_type <= MSG_NOP;
      r_ctrl_number   <= '0;
      r_grant_id      <= '0;
      r_tx_done       <= 1'b0;
      r_tx_error      <= 1'b0;
    end else begin
      r_tx_done  <= w_done;
      r_tx_error <= w_error;
      if (w_capture) begin
        r_ctrl_msg_type <= w_sel_type;
        r_ctrl_number   <= w_sel_num;
        r_grant_id      <= w_grant_idx;
        r_retry         <= '0;
        if (int'(w_grant_idx) == N_REQ - 1) r_ptr <= '0;
        else                                r_ptr <= PTR_W'(w_grant_idx) + PTR_W'(1);
      end
      if (w_retry_inc) r_retry <= r_retry + RTY_W'(1);
      if (w_timer_clr)      r_timer <= '0;
      else if (w_timer_inc) r_timer <= r_timer + TMR_W'(1);
    end
  end

  assign bus.req_ready     = w_grant;
  assign bus.transmit      = (r_state == ST_LAUNCH);
  assign bus.ctrl_en       = (r_state == ST_LAUNCH);
  assign bus.ctrl_msg_type = r_ctrl_msg_type;
  assign bus.ctrl_number   = r_ctrl_number;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.grant_id      = r_grant_id;
  assign bus.tx_done       = r_tx_done;
  assign bus.tx_error      = r_tx_error;

endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// Purpose: self-checking bench for interboard_tx_scheduler (N_REQ=2, ACK_TIMEOUT=8, DONE_TIMEOUT=16, MAX_RETRY=3).
// Latency: n/a. Backpressure: link behaviour modelled by hand per sequence.
// Inputs driven at posedge+1, outputs sampled at negedge.
module tb_interboard_tx_scheduler;

  localparam int N_REQ   = 2;
  localparam int ACK_TO  = 8;
  localparam int DONE_TO = 16;
  localparam int MAX_RTY = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  interboard_tx_scheduler_if #(.N_REQ(N_REQ)) bus ();

  interboard_tx_scheduler #(
    .N_REQ(N_REQ), .ACK_TIMEOUT(ACK_TO), .DONE_TIMEOUT(DONE_TO), .MAX_RETRY(MAX_RTY)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] valid;
    logic [5:0] types;
    logic [9:0] nums;
    logic [1:0] exp_ready;
    int         exp_gid;
    int         exp_type;
    int         exp_num;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // One full message: accept, launch, link goes busy 2 cycles after transmit, idle 10 cycles later.
  task automatic run_msg(input vec_t v, input int idx);
    string tag;
    int    n;
    int    dcnt;
    tag = $sformatf("vec%0d", idx);
    n   = 0;
    cyc();
    bus.req_valid    = v.valid;
    bus.req_msg_type = v.types;
    bus.req_number   = v.nums;
    smp();
    while (bus.req_ready == '0 && n < 20) begin
      cyc();
      smp();
      n++;
    end
    chk({tag, " accept"}, int'(bus.req_ready), int'(v.exp_ready));
    cyc();
    bus.req_valid = '0;
    smp();
    chk({tag, " transmit"}, int'(bus.transmit & bus.ctrl_en), 1);
    chk({tag, " ctrl_type"}, int'(bus.ctrl_msg_type), v.exp_type);
    chk({tag, " ctrl_num"}, int'(bus.ctrl_number), v.exp_num);
    chk({tag, " grant_id"}, int'(bus.grant_id), v.exp_gid);
    chk({tag, " ready_off"}, int'(bus.req_ready), 0);
    cyc();
    smp();
    chk({tag, " busy"}, int'(bus.busy), 1);
    cyc();
    bus.inter_ready = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      smp();
      dcnt += int'(bus.tx_done);
      cyc();
    end
    bus.inter_ready = 1'b1;
    smp();
    dcnt += int'(bus.tx_done);
    chk({tag, " done_early"}, dcnt, 0);
    cyc();
    smp();
    chk({tag, " done_pulse"}, int'(bus.tx_done), 1);
    chk({tag, " idle_after"}, int'(bus.busy), 0);
    cyc();
    smp();
    chk({tag, " done_single"}, int'(bus.tx_done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_pos[$];
    int err_pos[$];
    int bad;
    int dn;

    vecs[0] = '{valid: 2'b01, types: {3'd0, 3'd2}, nums: {5'd0, 5'd17}, exp_ready: 2'b01, exp_gid: 0, exp_type: 2, exp_num: 17};
    vecs[1] = '{valid: 2'b10, types: {3'd4, 3'd0}, nums: {5'd31, 5'd0}, exp_ready: 2'b10, exp_gid: 1, exp_type: 4, exp_num: 31};
    vecs[2] = '{valid: 2'b11, types: {3'd5, 3'd1}, nums: {5'd9, 5'd3},  exp_ready: 2'b01, exp_gid: 0, exp_type: 1, exp_num: 3};
    vecs[3] = '{valid: 2'b11, types: {3'd5, 3'd1}, nums: {5'd9, 5'd3},  exp_ready: 2'b10, exp_gid: 1, exp_type: 5, exp_num: 9};
    vecs[4] = '{valid: 2'b11, types: {3'd7, 3'd0}, nums: {5'd0, 5'd31}, exp_ready: 2'b01, exp_gid: 0, exp_type: 0, exp_num: 31};
    vecs[5] = '{valid: 2'b11, types: {3'd7, 3'd0}, nums: {5'd0, 5'd31}, exp_ready: 2'b10, exp_gid: 1, exp_type: 7, exp_num: 0};

    // Reset state, with a pending request that must not be granted while reset is held.
    bus.req_valid    = 2'b01;
    bus.req_msg_type = 6'd2;
    bus.req_number   = 10'd17;
    bus.inter_ready  = 1'b1;
    #3;
    chk("rst busy", int'(bus.busy), 0);
    chk("rst transmit", int'(bus.transmit | bus.ctrl_en), 0);
    chk("rst ctrl", int'({bus.ctrl_msg_type, bus.ctrl_number}), 0);
    chk("rst grant_id", int'(bus.grant_id), 0);
    chk("rst pulses", int'({bus.tx_done, bus.tx_error}), 0);
    chk("rst ready", int'(bus.req_ready), 0);
    bus.req_valid = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    smp();

    // Single request, then round-robin contention.
    for (int i = 0; i < 6; i++) run_msg(vecs[i], i);

    // Link busy: requester 1 waits, grant comes in the cycle inter_ready returns.
    cyc();
    bus.inter_ready  = 1'b0;
    bus.req_valid    = 2'b10;
    bus.req_msg_type = {3'd6, 3'd0};
    bus.req_number   = {5'd12, 5'd0};
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      smp();
      if (bus.req_ready != '0 || bus.transmit) bad++;
      cyc();
    end
    chk("linkbusy hold", bad, 0);
    bus.inter_ready = 1'b1;
    smp();
    chk("linkbusy grant", int'(bus.req_ready), 2);

    // No pickup: inter_ready stays high, expect 4 launches 9 apart, then an error.
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (k == 0) bus.req_valid = '0;
      smp();
      if (bus.transmit) tx_pos.push_back(k);
      if (bus.tx_error) err_pos.push_back(k);
      if (k == 35) chk("nopickup busy", int'(bus.busy), 1);
      if (k == 36) chk("nopickup idle", int'(bus.busy), 0);
    end
    chk("nopickup launches", tx_pos.size(), 4);
    foreach (tx_pos[i]) chk($sformatf("nopickup launch%0d", i), tx_pos[i], 9 * i);
    chk("nopickup errors", err_pos.size(), 1);
    chk("nopickup error time", (err_pos.size() > 0) ? err_pos[0] : -1, 36);
    chk("nopickup held num", int'(bus.ctrl_number), 12);

    // Hang: link goes busy and never comes back.
    tx_pos.delete();
    err_pos.delete();
    dn = 0;
    cyc();
    bus.req_valid    = 2'b10;
    bus.req_msg_type = {3'd3, 3'd0};
    bus.req_number   = {5'd7, 5'd0};
    smp();
    chk("hang accept", int'(bus.req_ready), 2);
    for (int k = 0; k < 26; k++) begin
      cyc();
      if (k == 0) bus.req_valid = '0;
      if (k == 1) bus.inter_ready = 1'b0;
      smp();
      if (bus.transmit) tx_pos.push_back(k);
      if (bus.tx_error) err_pos.push_back(k);
      dn += int'(bus.tx_done);
      if (k == 18) chk("hang idle", int'(bus.busy), 0);
    end
    chk("hang launches", tx_pos.size(), 1);
    chk("hang errors", err_pos.size(), 1);
    chk("hang error time", (err_pos.size() > 0) ? err_pos[0] : -1, 18);
    chk("hang no done", dn, 0);
    bus.inter_ready = 1'b1;

    // Reset mid-transfer: requester 0 served so the pointer sits at 1 before reset.
    cyc();
    bus.req_valid    = 2'b01;
    bus.req_msg_type = {3'd0, 3'd6};
    bus.req_number   = {5'd0, 5'd21};
    smp();
    chk("rstmid accept", int'(bus.req_ready), 1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k == 0) bus.req_valid = '0;
      if (k == 1) bus.inter_ready = 1'b0;
      smp();
    end
    chk("rstmid busy", int'(bus.busy), 1);
    chk("rstmid type", int'(bus.ctrl_msg_type), 6);
    bus.req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid async busy", int'(bus.busy), 0);
    chk("rstmid async ctrl", int'({bus.ctrl_msg_type, bus.ctrl_number}), 0);
    chk("rstmid async grant_id", int'(bus.grant_id), 0);
    bus.inter_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      smp();
      if (bus.req_ready != '0 || bus.transmit || bus.tx_done || bus.tx_error || bus.busy) bad++;
    end
    chk("rstmid quiet", bad, 0);
    cyc();
    rst_n = 1'b1;
    smp();
    chk("rstmid ptr reset", int'(bus.req_ready), 1);
    chk("rstmid no pulse", int'({bus.tx_done, bus.tx_error}), 0);
    cyc();
    bus.req_valid = '0;
    smp();
    chk("rstmid relaunch", int'(bus.transmit), 1);
    chk("rstmid grant_id", int'(bus.grant_id), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
